sd_data_crc_check: RTL

SD_DATA_CRC_CHECK -- requirements
Module: sd_data_crc_check

---
 rtl/sd_crc_pkg.sv | 17 +
 rtl/sd_crc16_lfsr.sv | 30 +++
 rtl/sd_data_crc_check.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sd_crc_pkg.sv
// Shared types and constants for the SD data-line CRC16 checker and its LFSR.
package sd_crc_pkg;

  localparam int unsigned CRC_W                = 16;
  localparam int unsigned BYTE_W               = 8;
  localparam logic [15:0] CRC16_CCITT_POLY     = 16'h1021;
  localparam int unsigned SD_BLOCK_LEN_DEFAULT = 512;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_CRC_HI = 3'd2,
    ST_CRC_LO = 3'd3,
    ST_DONE   = 3'd4
  } sd_crc_state_e;

endpackage

// File: rtl/sd_crc16_lfsr.sv
// Bit-serial CRC16 LFSR (MSB-first) with synchronous clear and step enable.
module sd_crc16_lfsr
  import sd_crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC16_CCITT_POLY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [CRC_W-1:0] o_crc
);

  logic [CRC_W-1:0] r_crc;
  logic             w_fb;

  assign w_fb  = r_crc[CRC_W-1] ^ i_bit;
  assign o_crc = r_crc;

  // Clear wins over a step so a restart never folds in a stale bit.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : CRC_W'(0));
    end
  end

endmodule

// File: rtl/sd_data_crc_check.sv
// Receive-side CRC16 check of one SD data block: data bytes, then CRC hi/lo.
// Optional mismatch counter enabled by defining SD_CRC_ERRCNT_EN.
module sd_data_crc_check
  import sd_crc_pkg::*;
#(
  parameter int unsigned      BLOCK_LEN = SD_BLOCK_LEN_DEFAULT,
  parameter logic [CRC_W-1:0] POLY      = CRC16_CCITT_POLY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              crc_ok,
  output logic [CRC_W-1:0]  crc_calc
`ifdef SD_CRC_ERRCNT_EN
  ,
  output logic [CRC_W-1:0]  err_count
`endif
);

  localparam int unsigned CNT_W = $clog2(BLOCK_LEN + 1);
  localparam int unsigned BIT_W = 4;

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_DATA   = ST_DATA;
  localparam logic [2:0] S_CRC_HI = ST_CRC_HI;
  localparam logic [2:0] S_CRC_LO = ST_CRC_LO;
  localparam logic [2:0] S_DONE   = ST_DONE;

  logic [2:0]        r_state,     w_nxt_state;
  logic [CNT_W-1:0]  r_byte_cnt,  w_nxt_byte_cnt;
  logic [BIT_W-1:0]  r_bit_cnt,   w_nxt_bit_cnt;
  logic [BYTE_W-1:0] r_shift,     w_nxt_shift;
  logic [BYTE_W-1:0] r_rx_hi,     w_nxt_rx_hi;
  logic              r_in_ready,  w_nxt_in_ready;
  logic              r_busy,      w_nxt_busy;
  logic              r_done,      w_nxt_done;
  logic              r_crc_ok,    w_nxt_crc_ok;
  logic [CRC_W-1:0]  r_crc_calc,  w_nxt_crc_calc;
`ifdef SD_CRC_ERRCNT_EN
  logic [CRC_W-1:0]  r_err_count, w_nxt_err_count;
`endif

  logic              w_hs;
  logic              w_lfsr_en;
  logic [CRC_W-1:0]  w_crc;

  assign w_hs      = in_valid && r_in_ready;
  assign w_lfsr_en = !start && (r_state == S_DATA) && (r_bit_cnt != '0);

  sd_crc16_lfsr #(
    .POLY (POLY)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .i_clr (start),
    .i_en  (w_lfsr_en),
    .i_bit (r_shift[BYTE_W-1]),
    .o_crc (w_crc)
  );

  // Next-state and next-output logic; start overrides everything but reset.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_byte_cnt = r_byte_cnt;
    w_nxt_bit_cnt  = r_bit_cnt;
    w_nxt_shift    = r_shift;
    w_nxt_rx_hi    = r_rx_hi;
    w_nxt_done     = 1'b0;
    w_nxt_crc_ok   = r_crc_ok;
    w_nxt_crc_calc = r_crc_calc;
`ifdef SD_CRC_ERRCNT_EN
    w_nxt_err_count = r_err_count;
`endif

    if (start) begin
      w_nxt_state    = S_DATA;
      w_nxt_byte_cnt = '0;
      w_nxt_bit_cnt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_nxt_state = S_IDLE;
        end
        S_DATA: begin
          if (r_bit_cnt != '0) begin
            w_nxt_shift   = {r_shift[BYTE_W-2:0], 1'b0};
            w_nxt_bit_cnt = r_bit_cnt - BIT_W'(1);
            if ((r_bit_cnt == BIT_W'(1)) && (r_byte_cnt == CNT_W'(BLOCK_LEN))) begin
              w_nxt_state = S_CRC_HI;
            end
          end else if (w_hs) begin
            w_nxt_shift    = in_data;
            w_nxt_bit_cnt  = BIT_W'(BYTE_W);
            w_nxt_byte_cnt = r_byte_cnt + CNT_W'(1);
          end
        end
        S_CRC_HI: begin
          if (w_hs) begin
            w_nxt_rx_hi = in_data;
            w_nxt_state = S_CRC_LO;
          end
        end
        S_CRC_LO: begin
          if (w_hs) begin
            w_nxt_state    = S_DONE;
            w_nxt_done     = 1'b1;
            w_nxt_crc_ok   = ({r_rx_hi, in_data} == w_crc);
            w_nxt_crc_calc = w_crc;
`ifdef SD_CRC_ERRCNT_EN
            if (({r_rx_hi, in_data} != w_crc) && (r_err_count != 16'hFFFF)) begin
              w_nxt_err_count = r_err_count + CRC_W'(1);
            end
`endif
          end
        end
        S_DONE: begin
          w_nxt_state = S_IDLE;
        end
        default: begin
          w_nxt_state = S_IDLE;
        end
      endcase
    end

    w_nxt_busy     = (w_nxt_state != S_IDLE);
    w_nxt_in_ready = ((w_nxt_state == S_DATA) || (w_nxt_state == S_CRC_HI) ||
                      (w_nxt_state == S_CRC_LO)) && (w_nxt_bit_cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_byte_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_rx_hi    <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_crc_ok   <= 1'b0;
      r_crc_calc <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_byte_cnt <= w_nxt_byte_cnt;
      r_bit_cnt  <= w_nxt_bit_cnt;
      r_shift    <= w_nxt_shift;
      r_rx_hi    <= w_nxt_rx_hi;
      r_in_ready <= w_nxt_in_ready;
      r_busy     <= w_nxt_busy;
      r_done     <= w_nxt_done;
      r_crc_ok   <= w_nxt_crc_ok;
      r_crc_calc <= w_nxt_crc_calc;
    end
  end

`ifdef SD_CRC_ERRCNT_EN
  // Saturating mismatch counter; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_count <= '0;
    end else begin
      r_err_count <= w_nxt_err_count;
    end
  end

  assign err_count = r_err_count;
`endif

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign crc_ok   = r_crc_ok;
  assign crc_calc = r_crc_calc;

endmodule
